spi_burst_reg_slave: RTL

- Parametrised SPI slave that bridges an external SPI master to the on-chip byte-wide register bus.
- Supports burst reads and writes with address auto-increment and wrap-around.
- Read data starts in the byte immediately after the command byte; there is no latency/dummy byte.
- Sits between the board SPI pins (sclk/mosi/miso/cs_n) and the register file that holds the system ID, version and LED control registers.

---
 rtl/spi_burst_reg_slave.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_burst_reg_slave.sv
// ---------------------------------------------------------------------------
// spi_burst_reg_slave
//
// SPI slave bridging an external SPI master onto a byte-wide register bus.
// The first byte of every frame is a command: bit 7 selects read (1) or
// write (0) and bits [ADDR_W-1:0] give the start address. The following
// bytes are burst data with address auto-increment and wrap at NUM_REGS-1.
// Read data starts in the byte immediately after the command, with no
// dummy byte in between.
//
// Parameters:
//   ADDR_W    register address width carried in the command byte
//   NUM_REGS  number of implemented registers (1..2**ADDR_W)
//   SPI_MODE  0 or 3. mosi is sampled on rising sclk, miso shifts on falling
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   sclk, cs_n    SPI clock / chip select (asynchronous to clk)
//   mosi, miso    SPI data in / out, miso_oe enables the miso pad
//   bus_addr      register address
//   bus_wdata     write data, bus_we one-clk write strobe
//   bus_re        one-clk read strobe, bus_rdata valid 1 clk after bus_re
//   busy          high while a frame is active
//   addr_err      one-clk pulse when the command addresses >= NUM_REGS
//   txn_done      one-clk pulse at frame end if >= 1 full byte was received
// ---------------------------------------------------------------------------
module spi_burst_reg_slave #(
  parameter int ADDR_W   = 7,
  parameter int NUM_REGS = 128,
  parameter int SPI_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_we,
  output logic              bus_re,
  input  logic [7:0]        bus_rdata,
  output logic              busy,
  output logic              addr_err,
  output logic              txn_done
);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
  // In mode 0 the MSB is placed on miso as soon as the byte is loaded, so
  // the falling edge that closes the previous byte must not shift.
  localparam bit MODE0 = (SPI_MODE == 0);

  // -------------------------------------------------------------------------
  // Input synchronisers: bit 0 = sclk, bit 1 = cs_n, bit 2 = mosi
  // -------------------------------------------------------------------------
  logic [2:0] pin_in;
  logic [2:0] pin_sync;

  assign pin_in = {mosi, cs_n, sclk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic s1_reg;
      logic s2_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= pin_in[gi];
          s2_reg <= s1_reg;
        end
      end
      assign pin_sync[gi] = s2_reg;
    end
  endgenerate

  logic sclk_s, cs_s, mosi_s;
  logic sclk_d_reg, cs_d_reg;

  assign sclk_s = pin_sync[0];
  assign cs_s   = pin_sync[1];
  assign mosi_s = pin_sync[2];

  // Delay stage for edge detection. Resetting cs_d_reg to 0 means a frame
  // already in progress at reset release cannot produce a falling edge
  // until cs_n has been seen high first.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_d_reg <= 1'b0;
      cs_d_reg   <= 1'b0;
    end else begin
      sclk_d_reg <= sclk_s;
      cs_d_reg   <= cs_s;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  assign sclk_rise = ~cs_s &  sclk_s & ~sclk_d_reg;
  assign sclk_fall = ~cs_s & ~sclk_s &  sclk_d_reg;
  assign cs_fall   =  cs_d_reg & ~cs_s;
  assign cs_rise   = ~cs_d_reg &  cs_s;

  // -------------------------------------------------------------------------
  // Frame state machine
  // -------------------------------------------------------------------------
  state_t      state_reg;
  logic [2:0]  bit_cnt_reg;
  logic [7:0]  rx_sh_reg;
  logic [7:0]  tx_sh_reg;
  logic        inv_reg;        // command addressed a missing register
  logic        byte_seen_reg;  // at least one full byte in this frame
  logic        skip_fall_reg;  // mode 0: next falling edge must not shift
  logic        fetch1_reg;     // read strobe cycle
  logic        fetch2_reg;     // read data valid cycle

  logic [7:0]        rx_next;
  logic              byte_end;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_bad;
  logic [7:0]        load_byte;

  assign rx_next   = {rx_sh_reg[6:0], mosi_s};
  assign byte_end  = sclk_rise && (bit_cnt_reg == 3'd7);
  assign cmd_addr  = rx_next[ADDR_W-1:0];
  assign cmd_bad   = ({1'b0, cmd_addr} >= NUM_REGS_W);
  // Invalid-address reads return zeros without touching the bus.
  assign load_byte = inv_reg ? 8'h00 : bus_rdata;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      bit_cnt_reg   <= 3'd0;
      rx_sh_reg     <= 8'h00;
      tx_sh_reg     <= 8'h00;
      inv_reg       <= 1'b0;
      byte_seen_reg <= 1'b0;
      skip_fall_reg <= 1'b0;
      fetch1_reg    <= 1'b0;
      fetch2_reg    <= 1'b0;
      miso          <= 1'b0;
      miso_oe       <= 1'b0;
      bus_addr      <= '0;
      bus_wdata     <= 8'h00;
      bus_we        <= 1'b0;
      bus_re        <= 1'b0;
      busy          <= 1'b0;
      addr_err      <= 1'b0;
      txn_done      <= 1'b0;
    end else begin
      bus_we     <= 1'b0;
      bus_re     <= 1'b0;
      addr_err   <= 1'b0;
      txn_done   <= 1'b0;
      fetch1_reg <= 1'b0;
      fetch2_reg <= fetch1_reg;

      if (state_reg != IDLE && cs_rise) begin
        // End of frame: any partial byte is simply dropped.
        state_reg     <= IDLE;
        busy          <= 1'b0;
        miso_oe       <= 1'b0;
        miso          <= 1'b0;
        txn_done      <= byte_seen_reg;
        bit_cnt_reg   <= 3'd0;
        rx_sh_reg     <= 8'h00;
        tx_sh_reg     <= 8'h00;
        inv_reg       <= 1'b0;
        skip_fall_reg <= 1'b0;
        fetch1_reg    <= 1'b0;
        fetch2_reg    <= 1'b0;
      end else if (state_reg == IDLE) begin
        if (cs_fall) begin
          state_reg     <= CMD;
          busy          <= 1'b1;
          miso_oe       <= 1'b1;
          miso          <= 1'b0;
          bit_cnt_reg   <= 3'd0;
          rx_sh_reg     <= 8'h00;
          tx_sh_reg     <= 8'h00;
          inv_reg       <= 1'b0;
          byte_seen_reg <= 1'b0;
          skip_fall_reg <= 1'b0;
        end
      end else begin
        // Address advances the cycle after a write so the strobe sees the
        // address it belongs to.
        if (bus_we) bus_addr <= next_addr(bus_addr);

        if (sclk_rise) begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          rx_sh_reg   <= rx_next;
        end
        if (byte_end) byte_seen_reg <= 1'b1;

        case (state_reg)
          CMD: begin
            if (byte_end) begin
              bus_addr <= cmd_addr;
              inv_reg  <= cmd_bad;
              addr_err <= cmd_bad;
              if (rx_next[7]) begin
                state_reg     <= RDATA;
                bus_re        <= ~cmd_bad;
                fetch1_reg    <= 1'b1;
                skip_fall_reg <= MODE0;
              end else begin
                state_reg <= WDATA;
              end
            end
          end

          WDATA: begin
            if (byte_end && !inv_reg) begin
              bus_we    <= 1'b1;
              bus_wdata <= rx_next;
            end
          end

          RDATA: begin
            if (byte_end) begin
              // Prefetch the next byte so it is ready before the next MSB.
              bus_addr      <= next_addr(bus_addr);
              bus_re        <= ~inv_reg;
              fetch1_reg    <= 1'b1;
              skip_fall_reg <= MODE0;
            end
            if (fetch2_reg) begin
              if (MODE0) begin
                miso      <= load_byte[7];
                tx_sh_reg <= {load_byte[6:0], 1'b0};
              end else begin
                tx_sh_reg <= load_byte;
              end
            end else if (sclk_fall) begin
              if (skip_fall_reg) begin
                skip_fall_reg <= 1'b0;
              end else begin
                miso      <= tx_sh_reg[7];
                tx_sh_reg <= {tx_sh_reg[6:0], 1'b0};
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule
